// File: rtl/pusch_bit_interleaver_pp_pkg.sv
// Shared types and helpers for the PUSCH ping-pong bit interleaver.
package bitint_pkg;

  localparam int unsigned QM_1 = 1;
  localparam int unsigned QM_2 = 2;
  localparam int unsigned QM_4 = 4;
  localparam int unsigned QM_6 = 6;
  localparam int unsigned QM_8 = 8;

  typedef enum logic {EMPTY, FULL} bank_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DIV, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;

  function automatic logic qm_legal(input int unsigned qm);
    return (qm == QM_1) || (qm == QM_2) || (qm == QM_4) || (qm == QM_6) || (qm == QM_8);
  endfunction

endpackage

// File: rtl/pusch_bit_interleaver_pp_seq_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses W cycles after start.
module seq_udiv #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  quo_q;
  logic [W-1:0]  rem_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          done_q;
  logic [W:0]    trial;
  logic          fits;

  always_comb begin
    trial = {rem_q, quo_q[W-1]};
    fits  = (trial >= {1'b0, divisor});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo_q <= dividend;
        rem_q <= '0;
        cnt_q <= CW'(W);
        run_q <= 1'b1;
      end else if (run_q) begin
        // A non-fitting trial is below the divisor, so its top bit is always zero.
        rem_q <= fits ? W'(trial - {1'b0, divisor}) : trial[W-1:0];
        quo_q <= {quo_q[W-2:0], fits};
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/pusch_bit_interleaver_pp.sv
// Ping-pong PUSCH bit interleaver: row-wise write into Qm rows, column-wise read.
// Define BITINT_BYPASS_EN to add cfg_bypass, which selects a linear (identity) read order.
module pusch_bit_interleaver_pp
  import bitint_pkg::*;
#(
  parameter int unsigned MAX_E = 94008,
  parameter int unsigned E_W   = 17,
  parameter int unsigned QM_W  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [E_W-1:0]  cfg_e,
  input  logic [QM_W-1:0] cfg_qm,
`ifdef BITINT_BYPASS_EN
  input  logic            cfg_bypass,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_data,
  output logic            out_last,
  output logic            err_cfg,
  output logic            busy
);

  wr_state_e       wr_state_q, wr_state_d;
  rd_state_e       rd_state_q, rd_state_d;
  bank_state_e     bank_q [2];
  logic            wbank_q, rbank_q;
  logic [E_W-1:0]  cur_e_q, rows_q, k_q;
  logic [QM_W-1:0] cur_qm_q;
  logic            cur_byp_q;
  logic [E_W-1:0]  meta_e_q [2];
  logic [E_W-1:0]  meta_rows_q [2];
  logic [QM_W-1:0] meta_qm_q [2];
  logic            meta_byp_q [2];
  logic [E_W-1:0]  addr_q, j_q, o_q;
  logic [QM_W-1:0] i_q;
  logic            loaded_q;
  logic            out_valid_q, out_data_q, out_last_q, err_q;
  logic            mem_q [2][MAX_E];

  logic            cfg_byp, basic_ok, cfg_hs, div_start, div_done, err_d;
  logic            wr_en, fill_done, rd_start, rd_load, drain_done, rd_end;
  logic [E_W-1:0]  div_quo, div_rem, rd_e, rd_rows;
  logic [QM_W-1:0] rd_qm;
  logic            rd_byp;

`ifdef BITINT_BYPASS_EN
  assign cfg_byp = cfg_bypass;
`else
  assign cfg_byp = 1'b0;
`endif

  assign basic_ok = (cfg_e != '0) && (32'(cfg_e) <= MAX_E) && qm_legal(32'(cfg_qm));
  assign rd_e     = meta_e_q[rbank_q];
  assign rd_rows  = meta_rows_q[rbank_q];
  assign rd_qm    = meta_qm_q[rbank_q];
  assign rd_byp   = meta_byp_q[rbank_q];
  assign rd_end   = (o_q == rd_e - E_W'(1));

  // The divider also yields E mod Qm, which finishes validating the config.
  seq_udiv #(
    .W (E_W)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (cfg_e),
    .divisor   ({{(E_W - QM_W){1'b0}}, cfg_qm}),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    rd_state_d = rd_state_q;
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    cfg_hs     = 1'b0;
    div_start  = 1'b0;
    err_d      = 1'b0;
    wr_en      = 1'b0;
    fill_done  = 1'b0;
    rd_start   = 1'b0;
    rd_load    = 1'b0;
    drain_done = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        cfg_ready = (bank_q[wbank_q] == EMPTY) && !reset;
        if (cfg_valid && cfg_ready) begin
          cfg_hs = 1'b1;
          if (basic_ok) begin
            div_start  = 1'b1;
            wr_state_d = W_DIV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      W_DIV: begin
        if (div_done) begin
          if (div_rem != '0) begin
            err_d      = 1'b1;
            wr_state_d = W_IDLE;
          end else begin
            wr_state_d = W_FILL;
          end
        end
      end
      W_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (k_q == cur_e_q - E_W'(1)) begin
            fill_done  = 1'b1;
            wr_state_d = W_IDLE;
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    unique case (rd_state_q)
      R_IDLE: begin
        if (bank_q[rbank_q] == FULL) begin
          rd_start   = 1'b1;
          rd_state_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          drain_done = 1'b1;
          rd_state_d = R_IDLE;
        end else if (!loaded_q && (!out_valid_q || out_ready)) begin
          rd_load = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wbank_q][k_q] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q  <= W_IDLE;
      rd_state_q  <= R_IDLE;
      bank_q      <= '{default: EMPTY};
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      cur_e_q     <= '0;
      cur_qm_q    <= '0;
      cur_byp_q   <= 1'b0;
      rows_q      <= '0;
      k_q         <= '0;
      meta_e_q    <= '{default: '0};
      meta_rows_q <= '{default: '0};
      meta_qm_q   <= '{default: '0};
      meta_byp_q  <= '{default: 1'b0};
      addr_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      o_q         <= '0;
      loaded_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      err_q      <= err_d;
      if (cfg_hs) begin
        cur_e_q   <= cfg_e;
        cur_qm_q  <= cfg_qm;
        cur_byp_q <= cfg_byp;
      end
      if ((wr_state_q == W_DIV) && div_done) begin
        rows_q <= div_quo;
        k_q    <= '0;
      end
      if (wr_en) begin
        k_q <= k_q + E_W'(1);
      end
      if (fill_done) begin
        bank_q[wbank_q]      <= FULL;
        meta_e_q[wbank_q]    <= cur_e_q;
        meta_rows_q[wbank_q] <= rows_q;
        meta_qm_q[wbank_q]   <= cur_qm_q;
        meta_byp_q[wbank_q]  <= cur_byp_q;
        wbank_q              <= ~wbank_q;
      end
      if (drain_done) begin
        bank_q[rbank_q] <= EMPTY;
        rbank_q         <= ~rbank_q;
      end
      if (rd_start) begin
        addr_q   <= '0;
        i_q      <= '0;
        j_q      <= '0;
        o_q      <= '0;
        loaded_q <= 1'b0;
      end
      if (rd_load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mem_q[rbank_q][addr_q];
        out_last_q  <= rd_end;
        loaded_q    <= rd_end;
        o_q         <= o_q + E_W'(1);
        // Column-wise walk: step down a column by rows, then restart at the next column top.
        if (rd_byp) begin
          addr_q <= addr_q + E_W'(1);
        end else if (i_q != rd_qm - QM_W'(1)) begin
          i_q    <= i_q + QM_W'(1);
          addr_q <= addr_q + rd_rows;
        end else begin
          i_q    <= '0;
          j_q    <= j_q + E_W'(1);
          addr_q <= j_q + E_W'(1);
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign err_cfg   = err_q;
  assign busy      = (wr_state_q == W_FILL) || (rd_state_q == R_DRAIN) ||
                     (bank_q[0] == FULL) || (bank_q[1] == FULL);

endmodule

// File: tb/tb_pusch_bit_interleaver_pp.sv
// Scoreboard bench for pusch_bit_interleaver_pp: expected bits queued at stimulus time.
module tb_pusch_bit_interleaver_pp;

  localparam int E_W  = 17;
  localparam int QM_W = 4;

  typedef struct packed {
    logic d;
    logic l;
  } obit_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [E_W-1:0]  cfg_e = '0;
  logic [QM_W-1:0] cfg_qm = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_data = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_data;
  logic            out_last;
  logic            err_cfg;
  logic            busy;

  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    cyc = 0;
  int    t_last_in = 0;
  int    t_first_out = 0;
  int    stall_bad = 0;
  bit    overlap_seen = 1'b0;
  logic  cfg_after_last = 1'b0;
  obit_t exp_q[$];
  obit_t got_q[$];

  pusch_bit_interleaver_pp dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_e      (cfg_e),
    .cfg_qm     (cfg_qm),
`ifdef BITINT_BYPASS_EN
    .cfg_bypass (1'b0),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .err_cfg    (err_cfg),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  task automatic drive_cfg(input int e, input int qm);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (cfg_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL cfg_ready_wait got %b want 1 (E=%0d)", cfg_ready, e);
    end
    cfg_valid = 1'b1;
    cfg_e     = E_W'(e);
    cfg_qm    = QM_W'(qm);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic drive_bit(input logic b, output bit ok);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    ok = (in_ready === 1'b1);
    if (!ok) begin
      total_cnt++;
      $display("FAIL in_ready_wait got %b want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
  endtask

  // mode 0: e[k] = k mod 2, otherwise random bits.
  task automatic send_frame(input int e, input int qm, input int mode);
    logic  bits[$];
    obit_t t;
    int    rows, idx;
    bit    ok;
    bits = {};
    for (int k = 0; k < e; k++) begin
      bits.push_back((mode == 0) ? logic'(k % 2) : logic'($urandom_range(0, 1)));
    end
    rows = e / qm;
    for (int o = 0; o < e; o++) begin
      idx = (o % qm) * rows + (o / qm);
      t.d = bits[idx];
      t.l = (o == e - 1);
      exp_q.push_back(t);
    end
    drive_cfg(e, qm);
    for (int k = 0; k < e; k++) begin
      drive_bit(bits[k], ok);
      if (!ok) break;
    end
    in_valid  = 1'b0;
    t_last_in = cyc;
  endtask

  task automatic collect(input int nbits, input bit rnd, input int ovl_lim);
    int    n = 0;
    bit    seen = 0, holding = 0, saw_last = 0, got_cfg = 0;
    logic  hd = 0, hl = 0;
    obit_t g;
    while (got_q.size() < nbits && n < 3000) begin
      if (out_valid === 1'b1 && !seen) begin
        seen = 1;
        t_first_out = cyc;
      end
      if (holding && (out_valid !== 1'b1 || out_data !== hd || out_last !== hl)) stall_bad++;
      if (saw_last && !got_cfg) begin
        got_cfg = 1;
        cfg_after_last = cfg_ready;
      end
      if (in_ready === 1'b1 && got_q.size() > 0 && got_q.size() < ovl_lim) overlap_seen = 1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      holding = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          g.d = out_data;
          g.l = out_last;
          got_q.push_back(g);
          if (out_last === 1'b1) saw_last = 1;
        end else begin
          holding = 1;
          hd = out_data;
          hl = out_last;
        end
      end
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({cfg_ready, in_ready, out_valid, out_data, out_last, err_cfg, busy} !== 7'b0)
      $display("FAIL reset_outputs got %b want 0000000",
               {cfg_ready, in_ready, out_valid, out_data, out_last, err_cfg, busy});
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %b want 1", cfg_ready);
    else pass_cnt++;
  endtask

  task automatic test_interleave_qm4;
    obit_t g, x;
    fork
      send_frame(12, 4, 0);
      collect(12, 1'b0, 0);
    join
    total_cnt++;
    if (t_first_out - t_last_in !== 2)
      $display("FAIL qm4_latency got %0d want 2", t_first_out - t_last_in);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== 12) $display("FAIL qm4_count got %0d want 12", got_q.size());
    else pass_cnt++;
    for (int b = 0; got_q.size() > 0 && exp_q.size() > 0; b++) begin
      g = got_q.pop_front(); x = exp_q.pop_front(); total_cnt++;
      if (g !== x) $display("FAIL qm4_bit%0d got d=%b l=%b want d=%b l=%b", b, g.d, g.l, x.d, x.l);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_qm6_qm1;
    obit_t g, x;
    fork
      begin
        send_frame(12, 6, 1);
        send_frame(12, 1, 1);
      end
      collect(24, 1'b0, 0);
    join
    total_cnt++;
    if (got_q.size() !== 24) $display("FAIL qm6_qm1_count got %0d want 24", got_q.size());
    else pass_cnt++;
    for (int b = 0; got_q.size() > 0 && exp_q.size() > 0; b++) begin
      g = got_q.pop_front(); x = exp_q.pop_front(); total_cnt++;
      if (g !== x) $display("FAIL qm6_qm1_bit%0d got d=%b l=%b want d=%b l=%b", b, g.d, g.l, x.d, x.l);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal;
    int ill_e[3] = '{10, 12, 0};
    int ill_q[3] = '{4, 3, 4};
    int errs;
    bit any_rdy, any_busy;
    for (int c = 0; c < 3; c++) begin
      drive_cfg(ill_e[c], ill_q[c]);
      errs = 0; any_rdy = 0; any_busy = 0;
      repeat (30) begin
        if (err_cfg === 1'b1) errs++;
        if (in_ready !== 1'b0) any_rdy = 1;
        if (busy !== 1'b0) any_busy = 1;
        @(posedge clk); #1;
      end
      total_cnt++;
      if (errs !== 1) $display("FAIL illegal%0d_err_pulse got %0d cycles want 1", c, errs);
      else pass_cnt++;
      total_cnt++;
      if (any_rdy || any_busy)
        $display("FAIL illegal%0d_quiet got in_ready=%b busy=%b want 0 0", c, any_rdy, any_busy);
      else pass_cnt++;
      total_cnt++;
      if (cfg_ready !== 1'b1) $display("FAIL illegal%0d_cfg_ready got %b want 1", c, cfg_ready);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    obit_t g, x;
    stall_bad = 0;
    overlap_seen = 0;
    fork
      begin
        send_frame(24, 2, 1);
        send_frame(48, 8, 1);
      end
      collect(72, 1'b1, 24);
    join
    total_cnt++;
    if (got_q.size() !== 72) $display("FAIL b2b_count got %0d want 72", got_q.size());
    else pass_cnt++;
    for (int b = 0; got_q.size() > 0 && exp_q.size() > 0; b++) begin
      g = got_q.pop_front(); x = exp_q.pop_front(); total_cnt++;
      if (g !== x) $display("FAIL b2b_bit%0d got d=%b l=%b want d=%b l=%b", b, g.d, g.l, x.d, x.l);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
    total_cnt++;
    if (stall_bad !== 0) $display("FAIL b2b_stall_hold got %0d changes want 0", stall_bad);
    else pass_cnt++;
    total_cnt++;
    if (overlap_seen !== 1'b1) $display("FAIL b2b_overlap got %b want 1", overlap_seen);
    else pass_cnt++;
  endtask

  task automatic test_both_full;
    obit_t g, x;
    logic  d0;
    stall_bad = 0;
    out_ready = 1'b0;
    send_frame(12, 2, 1);
    send_frame(6, 6, 1);
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({cfg_ready, in_ready} !== 2'b00)
      $display("FAIL full_ready got cfg=%b in=%b want 0 0", cfg_ready, in_ready);
    else pass_cnt++;
    d0 = out_data;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, exp_q[0].d})
      $display("FAIL full_hold got v=%b d=%b was d=%b want v=1 d=%b", out_valid, out_data, d0,
               exp_q[0].d);
    else pass_cnt++;
    cfg_after_last = 1'b0;
    collect(18, 1'b0, 0);
    total_cnt++;
    if (cfg_after_last !== 1'b1)
      $display("FAIL full_cfg_reopen got %b want 1", cfg_after_last);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== 18) $display("FAIL full_count got %0d want 18", got_q.size());
    else pass_cnt++;
    for (int b = 0; got_q.size() > 0 && exp_q.size() > 0; b++) begin
      g = got_q.pop_front(); x = exp_q.pop_front(); total_cnt++;
      if (g !== x) $display("FAIL full_bit%0d got d=%b l=%b want d=%b l=%b", b, g.d, g.l, x.d, x.l);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    obit_t g, x;
    bit    ok;
    drive_cfg(12, 2);
    for (int k = 0; k < 4; k++) drive_bit(logic'(k % 2), ok);
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({cfg_ready, in_ready, out_valid, out_data, out_last, err_cfg, busy} !== 7'b0)
      $display("FAIL reset_fill got %b want 0000000",
               {cfg_ready, in_ready, out_valid, out_data, out_last, err_cfg, busy});
    else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_frame(12, 2, 1);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({cfg_ready, in_ready, out_valid, out_data, out_last, err_cfg, busy} !== 7'b0)
      $display("FAIL reset_drain got %b want 0000000",
               {cfg_ready, in_ready, out_valid, out_data, out_last, err_cfg, busy});
    else pass_cnt++;
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    fork
      send_frame(6, 2, 1);
      collect(6, 1'b0, 0);
    join
    total_cnt++;
    if (got_q.size() !== 6) $display("FAIL post_reset_count got %0d want 6", got_q.size());
    else pass_cnt++;
    for (int b = 0; got_q.size() > 0 && exp_q.size() > 0; b++) begin
      g = got_q.pop_front(); x = exp_q.pop_front(); total_cnt++;
      if (g !== x) $display("FAIL post_reset_bit%0d got d=%b l=%b want d=%b l=%b", b, g.d, g.l, x.d, x.l);
      else pass_cnt++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_interleave_qm4();
    test_qm6_qm1();
    test_illegal();
    test_back_to_back();
    test_both_full();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pusch_bit_interleaver_pp.md
Name: pusch_bit_interleaver_pp

Overview:
Parametrised, double-buffered (ping-pong) bit interleaver for the PUSCH chain. It sits between rate matching and scrambling.
- Implements the 38.212 bit interleave: input e[k] is written row-wise into Qm rows of E/Qm bits; output f is read column-wise.
- Exact integer row count, with no fixed-point 1/Qm approximation.
- Accepts the next codeword while the previous one drains.
- Valid/ready handshakes on all streams.

Parameters:
MAX_E, 94008, maximum codeword bits per bank (divisible by 6 and 8)
E_W, 17, width of E and of all bit counters/addresses (2^E_W > MAX_E)
QM_W, 4, width of the Qm field

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  config offer for the next codeword
cfg_ready  out  1  config accepted when high with cfg_valid
cfg_e  in  E_W  codeword length E in bits
cfg_qm  in  QM_W  modulation order; legal values 1,2,4,6,8
in_valid  in  1  input bit valid
in_ready  out  1  input bit accepted when high with in_valid
in_data  in  1  input bit e[k]
out_valid  out  1  output bit valid
out_ready  in  1  downstream accepts
out_data  out  1  output bit f[o]
out_last  out  1  high on the final bit of a codeword
err_cfg  out  1  one-cycle pulse on a rejected config
busy  out  1  any bank filling or draining

Behaviour:
- Reset: clk edge with reset=1 clears everything; a frame in progress at that edge is discarded.
  - cfg_ready=0, in_ready=0, out_valid=0, out_data=0, out_last=0, err_cfg=0, busy=0.
  - Both banks go to EMPTY; write FSM to W_IDLE; read FSM to R_IDLE.
  - cfg_ready rises on the first cycle after reset deasserts.
- Storage: two banks of MAX_E bits each (bank0/bank1). The write pointer bank toggles after each fill; the read pointer bank toggles after each drain.
- Write FSM:
  - W_IDLE: cfg_ready=1 iff the write bank is EMPTY.
  - On a cfg handshake: latch E and Qm, then validate.
  - Illegal config (E=0, E>MAX_E, Qm not in {1,2,4,6,8}, or E mod Qm != 0): err_cfg=1 for exactly one cycle; stay in W_IDLE; nothing is stored.
  - Legal config: go to W_DIV.
- W_DIV: start seq_udiv on E/Qm. Wait for done (exactly E_W cycles); latch rows = quotient; go to W_FILL.
- W_FILL: in_ready=1.
  - Each handshake writes bank[wbank][k] = in_data, then k++.
  - On accepting bit k=E-1: mark the bank FULL with its E, Qm and rows; toggle wbank; go to W_IDLE.
- Read FSM:
  - R_IDLE: when the read bank is FULL, load addr=0, j=0, i=0 and go to R_DRAIN.
  - R_DRAIN: output f[i + j*Qm] = e[i*rows + j]. The address is computed incrementally; no multipliers.
    - If i<Qm-1: i++ and addr += rows.
    - Else: i=0, j++, addr = j+1.
- Read timing:
  - Registered, one-bit skid output: out_data/out_valid change only when !out_valid or out_ready.
  - out_last is asserted with bit o=E-1. After that handshake the bank becomes EMPTY, rbank toggles and the FSM returns to R_IDLE.
- Latency: the first output bit is valid 2 cycles after the last input handshake of the frame (handoff plus registered read), with out_ready held high. Sustained throughput is 1 bit/cycle on each side.
- Holds: out_valid=1 with out_ready=0 holds out_data and out_last stable indefinitely.
- Simultaneous events:
  - A fill completing in the same cycle a drain empties the other bank is legal: both transitions take effect.
  - cfg_ready may be high during R_DRAIN; the write FSM may be up to one codeword ahead.
- Qm=1: rows=E, and the output order equals the input order.
- Widths: i counts to Qm-1 (QM_W bits). j, addr, k and rows are E_W bits. addr never exceeds E-1 for a legal config.

Optional Feature:
BITINT_BYPASS_EN
- Defined: adds input port cfg_bypass (1 bit), latched with the config. When the latched value is 1, the read order is linear (addr++), giving output = input order for any Qm. Both banks and all handshakes behave unchanged.
- Undefined: the port is absent; the interleave order is always used.

Decomposition:
- Package bitint_pkg holds:
  - Constants: QM_1/2/4/6/8.
  - Typedefs: bank_state_e {EMPTY, FULL}, wr_state_e {W_IDLE, W_DIV, W_FILL}, rd_state_e {R_IDLE, R_DRAIN}.
  - Function qm_legal().
- One sub-module: seq_udiv, a restoring unsigned divider, E_W bits, fixed E_W-cycle latency, with start/done handshake and quotient/remainder outputs. The remainder is used for the E mod Qm check.

Test Plan:
- E=12, Qm=4, input e[k]=k mod 2 pattern, out_ready=1 -> rows=3, and the output index sequence is 0,3,6,9,1,4,7,10,2,5,8,11. out_last is asserted on the 12th bit, and the first bit is valid 2 cycles after the last input.
- E=12, Qm=6, then Qm=1 -> rows=2 with order 0,2,4,6,8,10,1,3,5,7,9,11; then identity order for Qm=1.
- Illegal configs E=10/Qm=4, Qm=3, and E=0 -> err_cfg is a single-cycle pulse each time, there is no in_ready, and busy=0.
- Back-to-back codewords E=24/Qm=2 and E=48/Qm=8 with random out_ready backpressure at 50% -> both streams are bit-exact against the model. in_ready for codeword 2 rises while codeword 1 drains. Stalls hold out_data stable.
- Both banks FULL with out_ready=0 -> cfg_ready=0 and in_ready=0. Raising out_ready reopens cfg_ready the cycle after out_last is accepted.
- reset=1 mid-W_FILL and mid-R_DRAIN -> all outputs at their reset values next cycle. A fresh E=6/Qm=2 frame then produces 0,3,1,4,2,5.
